// File: rtl/aes_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | aes_pkg : shared AES byte type, FSM encoding and S-box tables      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package aes_pkg;

   localparam int BLOCK_BYTES = 16;

   typedef logic [7:0] byte_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic byte_t gf_mul(input byte_t a, input byte_t b);
      byte_t p;
      byte_t aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
   function automatic byte_t gf_inv(input byte_t a);
      byte_t r;
      byte_t s;
      r = 8'h01;
      s = a;
      for (int i = 1; i < 8; i++) begin
         s = gf_mul(s, s);
         r = gf_mul(r, s);
      end
      return r;
   endfunction

   function automatic byte_t affine(input byte_t b);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [2047:0] gen_sbox_fwd();
      logic [2047:0] t;
      t = '0;
      for (int x = 0; x < 256; x++) begin
         t[8*x +: 8] = affine(gf_inv(8'(x)));
      end
      return t;
   endfunction

   function automatic logic [2047:0] gen_sbox_inv();
      logic [2047:0] fwd;
      logic [2047:0] t;
      byte_t         y;
      fwd = gen_sbox_fwd();
      t   = '0;
      for (int x = 0; x < 256; x++) begin
         y = fwd[8*x +: 8];
         t[{y, 3'b000} +: 8] = 8'(x);
      end
      return t;
   endfunction

   localparam logic [2047:0] SBOX_FWD_TBL = gen_sbox_fwd();
   localparam logic [2047:0] SBOX_INV_TBL = gen_sbox_inv();

endpackage
`default_nettype wire

// File: rtl/sbox_lane.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sbox_lane : combinational forward/inverse AES S-box byte lookup    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sbox_lane
   import aes_pkg::*;
(
   input  byte_t in_byte,
   input  logic  inv,
   output byte_t out_byte
);

   assign out_byte = inv ? SBOX_INV_TBL[{in_byte, 3'b000} +: 8]
                         : SBOX_FWD_TBL[{in_byte, 3'b000} +: 8];

endmodule
`default_nettype wire

// File: rtl/sub_bytes_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sub_bytes_seq : sequential AES SubBytes, LANES S-box lookups/cycle |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sub_bytes_seq
   import aes_pkg::*;
#(
   parameter int LANES       = 4,
   parameter int BLOCK_BYTES = aes_pkg::BLOCK_BYTES
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     inv,
   input  logic [BLOCK_BYTES*8-1:0] data_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [BLOCK_BYTES*8-1:0] data_out,
   output logic                     busy
);

   localparam int              CYCLES   = BLOCK_BYTES / LANES;
   localparam int              CW       = (CYCLES > 1) ? $clog2(CYCLES) : 1;
   localparam int              CHUNK_W  = LANES * 8;
   localparam int              BLOCK_W  = BLOCK_BYTES * 8;
   localparam logic [CW-1:0]   CNT_LAST = CW'(CYCLES - 1);

   if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16))
   begin : g_bad_lanes
      $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
   end

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [BLOCK_W-1:0]  src_q, src_d;
   logic [BLOCK_W-1:0]  data_out_q, data_out_d;
   logic                out_valid_q, out_valid_d;
   logic                busy_q, busy_d;
   logic                inv_q, inv_d;

   int                  chunk_base;
   logic [CHUNK_W-1:0]  chunk_src;
   logic [CHUNK_W-1:0]  chunk_sub;
   logic                accept;

   assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign data_out  = data_out_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;

   always_comb begin
      chunk_base = int'(cnt_q) * CHUNK_W;
      chunk_src  = src_q[chunk_base +: CHUNK_W];
   end

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      sbox_lane u_sbox (
         .in_byte  (chunk_src[8*j +: 8]),
         .inv      (inv_q),
         .out_byte (chunk_sub[8*j +: 8])
      );
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      src_d       = src_q;
      data_out_d  = data_out_q;
      out_valid_d = out_valid_q;
      inv_d       = inv_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (state_q == ST_DONE && out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
            // DONE with out_ready overlaps hand-off and the next accept
            if (accept) begin
               src_d       = data_in;
               inv_d       = inv;
               data_out_d  = '0;
               cnt_d       = '0;
               out_valid_d = 1'b0;
               state_d     = ST_BUSY;
            end
         end
         ST_BUSY: begin
            data_out_d[chunk_base +: CHUNK_W] = chunk_sub;
            if (cnt_q == CNT_LAST) begin
               out_valid_d = 1'b1;
               state_d     = ST_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         src_q       <= '0;
         data_out_q  <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         inv_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         src_q       <= src_d;
         data_out_q  <= data_out_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         inv_q       <= inv_d;
      end
   end

endmodule
`default_nettype wire
